// File: rtl/bcd_switch_reader_pkg.sv
// Shared definitions for the BCD thumbwheel switch reader.
// Holds the frame geometry, output width and range, sequencer state
// encoding, and a helper that extracts one BCD digit from a captured frame.
package bcd_switch_reader_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_BITS = 4;
  localparam int FRAME_BITS = 16;
  localparam int BIN_WIDTH  = 10;
  localparam int BIN_MAX    = 1023;
  // 9999 needs 14 bits; the accumulator is kept at this width.
  localparam int ACC_WIDTH  = 14;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CONVERT = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Digit index 0 is the thousands digit (frame MSBs), 3 is the units digit.
  function automatic logic [DIGIT_BITS-1:0] frame_digit(
    input logic [FRAME_BITS-1:0] frame,
    input logic [1:0]            idx
  );
    logic [DIGIT_BITS-1:0] d;
    case (idx)
      2'd0:    d = frame[15:12];
      2'd1:    d = frame[11:8];
      2'd2:    d = frame[7:4];
      default: d = frame[3:0];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bcd_switch_reader_if.sv
// Signal bundle between the switch reader, its shift-register chain and
// the consumer of the decoded value.
//   sample : read request (one cycle)
//   SDin   : serial data from the chain (QH)
//   Sftclk : chain shift clock
//   Ldclk  : chain parallel load, active-low
//   bin    : last valid decoded value
//   valid  : one-cycle pulse when bin updates
//   err    : set when the last frame was rejected
// slave = the reader, master = the surrounding system / chain.
interface bcd_switch_reader_if;
  import bcd_switch_reader_pkg::*;

  logic                 sample;
  logic                 SDin;
  logic                 Sftclk;
  logic                 Ldclk;
  logic [BIN_WIDTH-1:0] bin;
  logic                 valid;
  logic                 err;

  modport slave (
    input  sample,
    input  SDin,
    output Sftclk,
    output Ldclk,
    output bin,
    output valid,
    output err
  );

  modport master (
    output sample,
    output SDin,
    input  Sftclk,
    input  Ldclk,
    input  bin,
    input  valid,
    input  err
  );

endinterface

// File: rtl/bcd_switch_reader_bcd2binary.sv
// bcd2binary: converts a captured 4-digit BCD frame to binary by
// accumulating acc = acc*10 + digit, thousands first, one digit per cycle.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_i       : one-cycle pulse, first digit is absorbed on this edge
//   frame_i       : 16-bit BCD frame, must stay stable during conversion
//   value_o       : 14-bit accumulated value
//   digit_err_o   : some digit of the frame was above 9
//   done_o        : one-cycle pulse, 4 cycles after start, value_o final
module bcd2binary
  import bcd_switch_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] frame_i,
  output logic [ACC_WIDTH-1:0]  value_o,
  output logic                  digit_err_o,
  output logic                  done_o
);

  logic [ACC_WIDTH-1:0]  acc_q;
  logic [1:0]            idx_q;
  logic                  busy_q;
  logic                  err_q;
  logic                  done_q;
  logic [1:0]            step_idx;
  logic [DIGIT_BITS-1:0] digit;
  logic                  digit_bad;

  assign step_idx  = start_i ? 2'd0 : idx_q;
  assign digit     = frame_digit(frame_i, step_idx);
  assign digit_bad = (digit > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      idx_q  <= 2'd0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        // First step from a zero accumulator: 0*10 + digit.
        acc_q  <= ACC_WIDTH'(digit);
        err_q  <= digit_bad;
        idx_q  <= 2'd1;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        acc_q  <= acc_q * ACC_WIDTH'(10) + ACC_WIDTH'(digit);
        err_q  <= err_q | digit_bad;
        idx_q  <= idx_q + 2'd1;
        if (idx_q == 2'(NUM_DIGITS - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign value_o     = acc_q;
  assign digit_err_o = err_q;
  assign done_o      = done_q;

endmodule

// File: rtl/bcd_switch_reader.sv
// bcd_switch_reader: reads a 4-digit BCD switch bank through a chain of
// parallel-in shift registers (74HC165 style), converts it to binary and
// publishes values in 0..1023.
// Ports:
//   clk   : clock, all logic on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_switch_reader_if (sample, SDin in;
//           Sftclk, Ldclk, bin, valid, err out, all registered)
// Timing (D = CLK_DIV, sample high in cycle N):
//   LOAD    N+1 .. N+D            Ldclk low
//   SHIFT   N+D+1 .. N+33D        16 periods, D low then D high
//   CONVERT N+33D+1 .. N+33D+4
//   DONE    N+33D+5               valid/err/bin visible this cycle
module bcd_switch_reader
  import bcd_switch_reader_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  bcd_switch_reader_if.slave bus
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e                state_q, state_d;
  logic [7:0]            div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  sftclk_q, sftclk_d;
  logic                  ldclk_q, ldclk_d;
  logic [BIN_WIDTH-1:0]  bin_q, bin_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic                  div_end;
  logic                  shift_done;
  logic                  conv_done;
  logic                  conv_digit_err;
  logic [ACC_WIDTH-1:0]  conv_value;

  assign div_end    = (div_q == DIV_LAST);
  // End of the high phase of the 16th bit period.
  assign shift_done = (state_q == SHIFT) && sftclk_q && div_end && (bit_q == 4'd15);

  // The converter absorbs its first digit on the edge that enters CONVERT,
  // so its done pulse lands in the last CONVERT cycle.
  bcd2binary u_bcd2binary (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (shift_done),
    .frame_i     (frame_q),
    .value_o     (conv_value),
    .digit_err_o (conv_digit_err),
    .done_o      (conv_done)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      sftclk_q <= 1'b0;
      ldclk_q  <= 1'b1;
      bin_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      sftclk_q <= sftclk_d;
      ldclk_q  <= ldclk_d;
      bin_q    <= bin_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Next state. sample is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.sample) state_d = LOAD;
      LOAD:    if (div_end)    state_d = SHIFT;
      SHIFT:   if (shift_done) state_d = CONVERT;
      CONVERT: if (conv_done)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of counters, frame and outputs. Outputs are computed one
  // cycle ahead so that the registered value matches the state being entered.
  always_comb begin
    div_d    = div_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    sftclk_d = sftclk_q;
    ldclk_d  = ldclk_q;
    bin_d    = bin_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        ldclk_d  = ~bus.sample;
        sftclk_d = 1'b0;
        div_d    = '0;
        bit_d    = '0;
      end
      LOAD: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (div_end) ldclk_d = 1'b1;
      end
      SHIFT: begin
        if (div_end) begin
          div_d    = '0;
          sftclk_d = ~sftclk_q;
          if (!sftclk_q) begin
            // Sftclk rises on this edge: take the bit the chain presents now.
            frame_d = {frame_q[FRAME_BITS-2:0], bus.SDin};
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      CONVERT: begin
        if (conv_done) begin
          if (!conv_digit_err && (conv_value <= ACC_WIDTH'(BIN_MAX))) begin
            bin_d   = conv_value[BIN_WIDTH-1:0];
            valid_d = 1'b1;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.Sftclk = sftclk_q;
  assign bus.Ldclk  = ldclk_q;
  assign bus.bin    = bin_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_switch_reader.sv
module tb_bcd_switch_reader;

  localparam int D   = 4;
  localparam int LAT = 33 * D + 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_switch_reader_if bus();

  bcd_switch_reader #(.CLK_DIV(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Switch chain: asynchronous parallel load while Ldclk is low, shift
  // towards QH on each Sftclk rise. QH shows the frame MSB after load.
  logic [15:0] frame_val = 16'h0000;
  logic [15:0] chain_q   = 16'h0000;
  always @(posedge bus.Sftclk or negedge bus.Ldclk) begin
    if (!bus.Ldclk) chain_q <= frame_val;
    else            chain_q <= {chain_q[14:0], 1'b0};
  end
  assign bus.SDin = chain_q[15];

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int vcyc   = -1;
  int rises  = 0;

  always @(posedge bus.Sftclk) rises <= rises + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Behavioural model: a frame accepted in cycle N drives the outputs by
  // cycle offset from N; the decoded result is plain decimal arithmetic.
  int          m_start = -1;
  logic [15:0] m_frame = 16'h0000;
  logic [9:0]  m_bin   = 10'd0;
  logic        m_err   = 1'b0;

  always @(negedge clk) begin : model_compare
    logic        idle_now;
    int          off;
    logic        exp_ld, exp_sft, exp_valid;
    int          d0, d1, d2, d3, val;
    logic [13:0] exp_vec, act_vec;
    exp_ld = 1'b1;
    exp_sft = 1'b0;
    exp_valid = 1'b0;
    if (!rst_n) begin
      m_start = -1;
      m_bin   = 10'd0;
      m_err   = 1'b0;
    end else begin
      idle_now = (m_start < 0);
      off      = cyc - m_start;
      if (!idle_now) begin
        exp_ld  = !(off >= 1 && off <= D);
        exp_sft = (off >= D + 1) && (off <= 33 * D) && (((off - D - 1) % (2 * D)) >= D);
        if (off == LAT) begin
          d3  = int'(m_frame[15:12]);
          d2  = int'(m_frame[11:8]);
          d1  = int'(m_frame[7:4]);
          d0  = int'(m_frame[3:0]);
          val = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
          if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9 || val > 1023) begin
            m_err = 1'b1;
          end else begin
            m_bin     = val[9:0];
            m_err     = 1'b0;
            exp_valid = 1'b1;
          end
          $display("frame %04h started %0d done %0d: exp bin=%0d valid=%0d err=%0d | dut bin=%0d valid=%0d err=%0d",
                   m_frame, m_start, cyc, m_bin, exp_valid, m_err, bus.bin, bus.valid, bus.err);
          m_start = -1;
        end
      end
      if (idle_now && bus.sample) begin
        m_start = cyc;
        m_frame = frame_val;
      end
    end
    exp_vec = {exp_ld, exp_sft, exp_valid, m_err, m_bin};
    act_vec = {bus.Ldclk, bus.Sftclk, bus.valid, bus.err, bus.bin};
    checks++;
    if (act_vec !== exp_vec) begin
      errors++;
      $display("FAIL cycle%0d {Ldclk,Sftclk,valid,err,bin} actual=%04h required=%04h", cyc, act_vec, exp_vec);
    end
    if (bus.valid === 1'b1) begin
      vcnt++;
      vcyc = cyc;
    end
  end

  // Stimulus tasks keep the driver 1 time unit after a rising edge.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_now();
    bus.sample = 1'b1;
    @(posedge clk);
    #1;
    bus.sample = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] f, input int eb, input int ee, input int ev, input string nm);
    int n, v0, r0;
    frame_val = f;
    v0 = vcnt;
    r0 = rises;
    n  = cyc;
    pulse_now();
    wait_until(n + LAT + 2);
    chk({nm, "_bin"}, int'(bus.bin), eb);
    chk({nm, "_err"}, int'(bus.err), ee);
    chk({nm, "_valid_count"}, vcnt - v0, ev);
    chk({nm, "_sftclk_rises"}, rises - r0, 16);
    if (ev > 0) chk({nm, "_latency"}, vcyc - n, 137);
  endtask

  initial begin : stimulus
    int n, n2, v0, r0;
    bus.sample = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_bin", int'(bus.bin), 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_err", int'(bus.err), 0);
    chk("reset_ldclk", int'(bus.Ldclk), 1);
    chk("reset_sftclk", int'(bus.Sftclk), 0);
    wait_until(cyc + 2);

    run_frame(16'h0512, 512,  0, 1, "f0512");
    run_frame(16'h1023, 1023, 0, 1, "f1023");
    run_frame(16'h0512, 512,  0, 1, "f0512b");
    run_frame(16'h1024, 512,  1, 0, "f1024");
    run_frame(16'h0000, 0,    0, 1, "f0000");
    run_frame(16'h00A5, 0,    1, 0, "f00A5");

    // Re-sample during SHIFT and in DONE, then a new frame in the next IDLE.
    frame_val = 16'h0777;
    v0 = vcnt;
    r0 = rises;
    n  = cyc;
    pulse_now();
    wait_until(n + 21);
    pulse_now();
    wait_until(n + LAT);
    pulse_now();
    frame_val = 16'h0300;
    n2 = cyc;
    chk("idle_after_done_cycle", n2 - n, 138);
    pulse_now();
    wait_until(n2 + 3);
    chk("resample_valid_count", vcnt - v0, 1);
    chk("resample_sftclk_rises", rises - r0, 16);
    chk("resample_bin", int'(bus.bin), 777);
    chk("resample_latency", vcyc - n, 137);
    v0 = vcnt;
    r0 = rises;
    wait_until(n2 + LAT + 2);
    chk("restart_bin", int'(bus.bin), 300);
    chk("restart_latency", vcyc - n2, 137);
    chk("restart_valid_count", vcnt - v0, 1);
    chk("restart_sftclk_rises", rises - r0, 16);

    // Reset in the high phase of bit 7 of SHIFT.
    frame_val = 16'h0999;
    n = cyc;
    pulse_now();
    wait_until(n + 66);
    chk("pre_reset_sftclk", int'(bus.Sftclk), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ldclk", int'(bus.Ldclk), 1);
    chk("async_reset_sftclk", int'(bus.Sftclk), 0);
    chk("async_reset_bin", int'(bus.bin), 0);
    chk("async_reset_valid", int'(bus.valid), 0);
    chk("async_reset_err", int'(bus.err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_until(cyc + 2);
    run_frame(16'h0042, 42, 0, 1, "f0042");
    run_frame(16'h9999, 42, 1, 0, "f9999");

    wait_until(cyc + 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_switch_reader.md
BCD_SWITCH_READER -- requirements
Module: bcd_switch_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per Sftclk half-period (legal 2..255).
REQ-002 SHALL have port clk, input, 1: single clock, all logic rising-edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port sample, input, 1: single-cycle read request.
REQ-005 SHALL have port SDin, input, 1: serial data from the 74HC165-style parallel-in shift-register chain (QH).
REQ-006 SHALL have port Sftclk, output, 1: chain shift clock.
REQ-007 SHALL have port Ldclk, output, 1: chain parallel load, active-low.
REQ-008 SHALL have port bin, output, 10: last valid decoded value.
REQ-009 SHALL have port valid, output, 1: one-cycle pulse when bin updates.
REQ-010 SHALL have port err, output, 1: sticky flag for the last frame, high if that frame was rejected.

Function
REQ-011 SHALL implement states IDLE, LOAD, SHIFT, CONVERT, DONE.
REQ-012 IDLE: Ldclk=1, Sftclk=0; on sample=1 in cycle N, SHALL enter LOAD at N+1.
REQ-013 LOAD SHALL hold Ldclk=0 for exactly CLK_DIV cycles (N+1..N+CLK_DIV), then enter SHIFT with Ldclk=1.
REQ-014 SHIFT SHALL run 16 bit periods; each period SHALL be Sftclk low for CLK_DIV cycles, then Sftclk high for CLK_DIV cycles.
REQ-015 SDin SHALL be captured on the clk edge where Sftclk goes 0->1.
REQ-016 Capture SHALL be MSB-first into a 16-bit frame: bits 15:12 = thousands, 11:8 = hundreds, 7:4 = tens, 3:0 = units.
REQ-017 After the 16th period, SHALL enter CONVERT with Sftclk=0.
REQ-018 CONVERT SHALL take exactly 4 cycles: acc <= acc*10 + digit, thousands first; acc SHALL be 14 bits, starting at 0.
REQ-019 A digit > 9 SHALL set a reject flag for the frame; conversion SHALL still complete 4 cycles.
REQ-020 DONE (1 cycle) SHALL, when acc <= 1023 and no reject: load bin <= acc[9:0], pulse valid=1, clear err.
REQ-021 DONE SHALL, otherwise: hold bin, keep valid=0, set err=1.
REQ-022 valid/err update SHALL occur at cycle N+33*CLK_DIV+5 (N+137 for CLK_DIV=4); then return to IDLE.
REQ-023 sample asserted in any state other than IDLE SHALL be ignored (no queueing).
REQ-024 sample asserted in the DONE cycle SHALL be ignored; sample in the following IDLE cycle SHALL start a new frame.
REQ-025 bin SHALL change only in DONE; outputs SHALL be registered (no combinational path from SDin or sample).

Reset
REQ-026 rst_n=0 SHALL asynchronously force the following, in any state, including mid-LOAD/SHIFT: state=IDLE, Ldclk=1, Sftclk=0, bin=0, valid=0, err=0, frame=0, acc=0, counters=0.
REQ-027 After rst_n deasserts, the first sample SHALL start a complete frame from LOAD; a partial frame SHALL never be converted.

Structure
REQ-028 Shared package SHALL hold: NUM_DIGITS=4, FRAME_BITS=16, BIN_WIDTH=10, BIN_MAX=1023, state encoding.
REQ-029 BCD-to-binary accumulate SHALL be a sub-module bcd2binary (start, 16-bit frame in, 14-bit value, digit_err, done after 4 cycles); the shift/load sequencer SHALL stay in bcd_switch_reader.

Verification (CLK_DIV=4, chain model presents frame MSB on SDin after load, shifts on Sftclk rise)
REQ-030 Frame 0x0512, pulse sample -> Ldclk low 4 cycles, 16 Sftclk pulses, valid at N+137, bin=512, err=0.
REQ-031 Frame 0x1023 -> bin=1023, valid=1, err=0.
REQ-032 Frame 0x1024 after a good 0x0512 -> valid stays 0, err=1, bin holds 512; then frame 0x0000 -> bin=0, valid pulse, err=0.
REQ-033 Frame 0x00A5 (digit >9) -> err=1, bin unchanged, no valid.
REQ-034 sample re-pulsed during SHIFT and in DONE -> ignored; exactly one valid pulse, exactly 16 Sftclk rises.
REQ-035 rst_n low at bit 7 of SHIFT -> immediately Ldclk=1, Sftclk=0, bin=0; next sample with frame 0x0042 -> bin=42 at N+137.
